dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port-B arbiter between the core MEM stage and a loader/debug master.
// The loader wins when the core is idle, or is forced in after STARVE_MAX denied request cycles.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_re,
  input  logic [3:0]  core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        ld_req,
  input  logic [3:0]  ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic [3:0]  bram_web,
  output logic [31:0] bram_addrb,
  output logic [31:0] bram_dib,
  input  logic [31:0] bram_dob,
  output logic [15:0] forced_cnt
);

  localparam int unsigned WCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 16;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_CORE   = 2'd1,
    RD_LOADER = 2'd2
  } rd_owner_e;

  rd_owner_e         rd_owner_q, rd_owner_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]     core_hold_q, core_hold_d;
  logic [CW-1:0]     forced_q, forced_d;
  logic              core_act;
  logic              starved;
  logic              ld_sel;

  // Ownership and BRAM port-B mux; nothing is issued while reset is held.
  always_comb begin
    core_act   = core_re | (core_we != 4'b0);
    starved    = (wait_cnt_q == WCW'(STARVE_MAX));
    ld_sel     = rst_n & ld_req & (~core_act | starved);
    ld_gnt     = ld_sel;
    core_stall = ld_sel & core_act;
    bram_web   = 4'b0;
    bram_addrb = core_addr;
    bram_dib   = core_wdata;
    if (ld_sel) begin
      bram_web   = ld_we;
      bram_addrb = ld_addr;
      bram_dib   = ld_wdata;
    end else if (rst_n) begin
      bram_web   = core_we;
    end
  end

  // Next-state for starvation counter, read-return owner, core hold and forced count.
  always_comb begin
    wait_cnt_d  = '0;
    rd_owner_d  = RD_NONE;
    core_hold_d = core_hold_q;
    forced_d    = forced_q;
    if (ld_req && !ld_sel && !starved) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
    if (ld_sel && (ld_we == 4'b0)) begin
      rd_owner_d = RD_LOADER;
    end else if (!ld_sel && core_re) begin
      rd_owner_d = RD_CORE;
    end
    if (rd_owner_q == RD_CORE) begin
      core_hold_d = bram_dob;
    end
    if (core_stall && (forced_q != {CW{1'b1}})) begin
      forced_d = forced_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      rd_owner_q  <= RD_NONE;
      core_hold_q <= '0;
      forced_q    <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rd_owner_q  <= rd_owner_d;
      core_hold_q <= core_hold_d;
      forced_q    <= forced_d;
    end
  end

  // Read return steering: the core sees its last loaded word while the loader owns the return.
  always_comb begin
    ld_rvalid  = (rd_owner_q == RD_LOADER);
    ld_rdata   = ld_rvalid ? bram_dob : '0;
    core_rdata = (rd_owner_q == RD_CORE) ? bram_dob : core_hold_q;
    forced_cnt = forced_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a read-first BRAM model and
// expected-read-data queues checked in the cycle after each read issue.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_re;
  logic [3:0]  core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall;
  logic        ld_req;
  logic [3:0]  ld_we;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        ld_gnt, ld_rvalid;
  logic [3:0]  bram_web;
  logic [31:0] bram_addrb, bram_dib;
  logic [31:0] bram_dob = 32'h0;
  logic [15:0] forced_cnt;

  logic        s_core_re;
  logic [3:0]  s_core_we;
  logic [31:0] s_core_addr, s_core_wdata, s_core_rdata;
  logic        s_core_stall;
  logic        s_ld_req;
  logic [3:0]  s_ld_we;
  logic [31:0] s_ld_addr, s_ld_wdata, s_ld_rdata;
  logic        s_ld_gnt, s_ld_rvalid;
  logic [3:0]  s_bram_web;
  logic [31:0] s_bram_addrb, s_bram_dib;
  logic [15:0] s_forced_cnt;

  logic [31:0] mem [0:255];
  logic [31:0] core_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] exp_hold;
  int          exp_forced;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .core_re(core_re), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_dib(bram_dib),
    .bram_dob(bram_dob), .forced_cnt(forced_cnt)
  );

  // Second instance forces a grant every cycle so the counter can reach saturation quickly.
  dmem_port_arbiter #(.STARVE_MAX(0)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .core_re(s_core_re), .core_we(s_core_we), .core_addr(s_core_addr),
    .core_wdata(s_core_wdata), .core_rdata(s_core_rdata), .core_stall(s_core_stall),
    .ld_req(s_ld_req), .ld_we(s_ld_we), .ld_addr(s_ld_addr), .ld_wdata(s_ld_wdata),
    .ld_gnt(s_ld_gnt), .ld_rvalid(s_ld_rvalid), .ld_rdata(s_ld_rdata),
    .bram_web(s_bram_web), .bram_addrb(s_bram_addrb), .bram_dib(s_bram_dib),
    .bram_dob(32'h0), .forced_cnt(s_forced_cnt)
  );

  // Read-first byte-write BRAM model on port B.
  always @(posedge clk) begin
    bram_dob <= mem[bram_addrb[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (bram_web[b]) mem[bram_addrb[9:2]][8*b +: 8] <= bram_dib[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    core_re = 1'b0; core_we = 4'h0; core_addr = 32'h0; core_wdata = 32'h0;
    ld_req = 1'b0; ld_we = 4'h0; ld_addr = 32'h0; ld_wdata = 32'h0;
  endtask

  // One cycle: inputs already driven at negedge; check returns of the previous
  // cycle, then this cycle's grant/stall/port-B values, then advance to next negedge.
  task automatic tick(input bit exp_gnt);
    logic       act;
    logic [31:0] v;
    #1;
    if (ld_q.size() > 0) begin
      v = ld_q.pop_front();
      check("ld_rvalid", 32'(ld_rvalid), 32'h1);
      check("ld_rdata", ld_rdata, v);
    end else begin
      check("ld_rvalid_idle", 32'(ld_rvalid), 32'h0);
      check("ld_rdata_idle", ld_rdata, 32'h0);
    end
    if (core_q.size() > 0) begin
      exp_hold = core_q.pop_front();
    end
    check("core_rdata", core_rdata, exp_hold);
    act = core_re | (core_we != 4'h0);
    check("ld_gnt", 32'(ld_gnt), 32'(exp_gnt));
    check("core_stall", 32'(core_stall), 32'(exp_gnt & act));
    check("forced_cnt", 32'(forced_cnt), 32'(exp_forced));
    if (exp_gnt) begin
      check("web_ld", 32'(bram_web), 32'(ld_we));
      check("addr_ld", bram_addrb, ld_addr);
      if (ld_we != 4'h0) check("dib_ld", bram_dib, ld_wdata);
      if (ld_we == 4'h0) ld_q.push_back(mem[ld_addr[9:2]]);
      if (act) exp_forced++;
    end else begin
      check("web_core", 32'(bram_web), 32'(core_we));
      check("addr_core", bram_addrb, core_addr);
      if (core_we != 4'h0) check("dib_core", bram_dib, core_wdata);
      if (core_re) core_q.push_back(mem[core_addr[9:2]]);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h10 >> 2] = 32'hDEADBEEF;
    mem[32'h50 >> 2] = 32'hA5A5A5A5;
    exp_hold = 32'h0;
    exp_forced = 0;
    rst_n = 1'b0;
    idle();
    s_core_re = 1'b0; s_core_we = 4'h0; s_core_addr = 32'h0; s_core_wdata = 32'h0;
    s_ld_req = 1'b0; s_ld_we = 4'h0; s_ld_addr = 32'h0; s_ld_wdata = 32'h0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check("rst_core_stall", 32'(core_stall), 32'h0);
    check("rst_ld_gnt", 32'(ld_gnt), 32'h0);
    check("rst_ld_rvalid", 32'(ld_rvalid), 32'h0);
    check("rst_ld_rdata", ld_rdata, 32'h0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_forced_cnt", 32'(forced_cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Core-only load
    core_re = 1'b1; core_addr = 32'h10;
    tick(1'b0);
    idle();
    tick(1'b0);
    check("core_load_word", exp_hold, 32'hDEADBEEF);

    // Loader write then back-to-back loader read with core idle
    ld_req = 1'b1; ld_we = 4'hF; ld_addr = 32'h20; ld_wdata = 32'h12345678;
    tick(1'b1);
    ld_we = 4'h0; ld_wdata = 32'h0;
    tick(1'b1);
    idle();
    tick(1'b0);
    tick(1'b0);

    // Starvation: core writes continuously, loader forced in on 5th and 10th request cycle
    core_we = 4'hF; core_addr = 32'h30; core_wdata = 32'h11111111;
    ld_req = 1'b1; ld_we = 4'h3; ld_addr = 32'h40; ld_wdata = 32'hCAFE0000;
    for (int i = 1; i <= 10; i++) tick(i == 5 || i == 10);
    idle();
    tick(1'b0);
    check("forced_after_starve", 32'(forced_cnt), 32'h2);

    // Core hold across a forced loader read
    core_re = 1'b1; core_addr = 32'h50;
    ld_req = 1'b1; ld_we = 4'h0; ld_addr = 32'h20;
    for (int i = 1; i <= 5; i++) tick(i == 5);
    idle();
    tick(1'b0);
    check("hold_value", core_rdata, 32'hA5A5A5A5);
    tick(1'b0);

    // Reset while a loader read is in flight
    ld_req = 1'b1; ld_we = 4'h0; ld_addr = 32'h20;
    #1;
    check("inflight_gnt", 32'(ld_gnt), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ld_gnt", 32'(ld_gnt), 32'h0);
    check("midrst_web", 32'(bram_web), 32'h0);
    ld_q.delete();
    core_q.delete();
    @(negedge clk); #1;
    check("midrst_rvalid", 32'(ld_rvalid), 32'h0);
    check("midrst_rdata", ld_rdata, 32'h0);
    check("midrst_core_rdata", core_rdata, 32'h0);
    check("midrst_core_stall", 32'(core_stall), 32'h0);
    check("midrst_forced", 32'(forced_cnt), 32'h0);
    idle();
    rst_n = 1'b1;
    exp_hold = 32'h0;
    exp_forced = 0;
    @(negedge clk);
    tick(1'b0);
    tick(1'b0);

    // Forced-count saturation on the every-cycle-forced instance
    s_core_re = 1'b1; s_ld_req = 1'b1;
    #1;
    check("sat_stall", 32'(s_core_stall), 32'h1);
    check("sat_start", 32'(s_forced_cnt), 32'h0);
    repeat (65534) @(negedge clk);
    #1;
    check("sat_fffe", 32'(s_forced_cnt), 32'hFFFE);
    @(negedge clk); #1;
    check("sat_ffff", 32'(s_forced_cnt), 32'hFFFF);
    @(negedge clk); #1;
    check("sat_hold", 32'(s_core_stall), 32'h1);
    check("sat_stays", 32'(s_forced_cnt), 32'hFFFF);
    s_core_re = 1'b0; s_ld_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
